// File: rtl/tcu_sparse_packer_pkg.sv
// Shared TCU 2:4 structured-sparse definitions: group geometry and mask encoding.
package tcu_sparse_packer_pkg;
  localparam int SPARSE_GRP  = 4;
  localparam int SPARSE_KEEP = 2;

  typedef logic [SPARSE_GRP-1:0] sparse_mask_t;

  // Mask used for padding and for all-equal groups: keep elements 0 and 1.
  localparam sparse_mask_t SPARSE_MASK_DFLT = 4'b0011;
endpackage

// File: rtl/tcu_sparse_packer_if.sv
// Dense-in / compacted-out / format-word streams of the sparse packer.
interface tcu_sparse_packer_if #(
  parameter int NUM_GROUPS = 4,
  parameter int ELEM_W     = 16,
  parameter int FMT_W      = 32
) ();
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_GROUPS*4*ELEM_W-1:0] in_data;
  logic                         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_GROUPS*2*ELEM_W-1:0] out_data;
  logic [NUM_GROUPS*4-1:0]      out_mask;
  logic                         fmt_valid;
  logic                         fmt_ready;
  logic [FMT_W-1:0]             fmt_data;

  modport slave (
    input  in_valid, in_data, in_last, out_ready, fmt_ready,
    output in_ready, out_valid, out_data, out_mask, fmt_valid, fmt_data
  );

  modport master (
    output in_valid, in_data, in_last, out_ready, fmt_ready,
    input  in_ready, out_valid, out_data, out_mask, fmt_valid, fmt_data
  );
endinterface

// File: rtl/tcu_sparse_packer_grp_sel.sv
// 2:4 selection for one group: keeps the two largest magnitudes (ties -> lower index)
// and compacts them in index order.
module tcu_sparse_packer_grp_sel
  import tcu_sparse_packer_pkg::*;
#(
  parameter int ELEM_W = 16
) (
  input  logic [SPARSE_GRP-1:0][ELEM_W-1:0]  elems_i,
  output sparse_mask_t                       mask_o,
  output logic [SPARSE_KEEP-1:0][ELEM_W-1:0] kept_o
);
  logic [SPARSE_GRP-1:0][SPARSE_GRP-1:0] beats;  // beats[i][j]: elem j outranks elem i

  for (genvar i = 0; i < SPARSE_GRP; i++) begin : g_i
    for (genvar j = 0; j < SPARSE_GRP; j++) begin : g_j
      if (i == j) begin : g_self
        assign beats[i][j] = 1'b0;
      end else begin : g_cmp
        // Sign bit ignored; NaN/Inf patterns naturally rank above all finites.
        assign beats[i][j] = (elems_i[j][ELEM_W-2:0] > elems_i[i][ELEM_W-2:0]) ||
                             ((elems_i[j][ELEM_W-2:0] == elems_i[i][ELEM_W-2:0]) && (j < i));
      end
    end
    assign mask_o[i] = ($countones(beats[i]) < SPARSE_KEEP);
  end

  // Exactly two mask bits are set: lowest goes to slot 0, highest to slot 1.
  always_comb begin
    kept_o[0] = elems_i[0];
    kept_o[1] = elems_i[1];
    for (int e = SPARSE_GRP - 1; e >= 0; e--)
      if (mask_o[e]) kept_o[0] = elems_i[e];
    for (int e = 0; e < SPARSE_GRP; e++)
      if (mask_o[e]) kept_o[1] = elems_i[e];
  end
endmodule

// File: rtl/tcu_sparse_packer.sv
// 2:4 sparse packer: S1 captures dense beats, S2 holds compacted beats; masks are
// gathered into packed format words on a separate, independently stalled stream.
module tcu_sparse_packer
  import tcu_sparse_packer_pkg::*;
#(
  parameter int NUM_GROUPS = 4,
  parameter int ELEM_W     = 16,
  parameter int FMT_W      = 32
) (
  input  logic                clk,
  input  logic                reset,
  tcu_sparse_packer_if.slave  sp
);
  localparam int MB     = NUM_GROUPS * SPARSE_GRP;
  localparam int BPF    = FMT_W / MB;
  localparam int CW     = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int STAGES = 2;

  logic [STAGES:1] vld_pipe_q, vld_pipe_d;
  logic [NUM_GROUPS-1:0][SPARSE_GRP-1:0][ELEM_W-1:0]  s1_data_q;
  logic                                               s1_last_q;
  logic [NUM_GROUPS-1:0][SPARSE_KEEP-1:0][ELEM_W-1:0] out_data_q, kept;
  sparse_mask_t [NUM_GROUPS-1:0]                      out_mask_q, beat_mask;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [FMT_W-1:0] acc_q, acc_d, fmt_data_q, fmt_word;
  logic             fmt_valid_q, fmt_valid_d;
  logic             s2_adv, s1_adv, fmt_ok, completes, xfer, in_ready;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    tcu_sparse_packer_grp_sel #(.ELEM_W(ELEM_W)) u_sel (
      .elems_i (s1_data_q[g]),
      .mask_o  (beat_mask[g]),
      .kept_o  (kept[g])
    );
  end

  assign completes = vld_pipe_q[1] & (s1_last_q | (cnt_q == CW'(BPF - 1)));
  // A completing beat waits in S1 until the format register can take its word.
  assign fmt_ok    = ~completes | ~fmt_valid_q | sp.fmt_ready;
  assign s2_adv    = ~vld_pipe_q[2] | sp.out_ready;
  assign s1_adv    = s2_adv & fmt_ok;
  assign in_ready  = ~reset & (~vld_pipe_q[1] | s1_adv);
  assign xfer      = vld_pipe_q[1] & s1_adv;

  always_comb begin
    fmt_word = '0;
    for (int k = 0; k < BPF; k++) begin
      if (k < int'(cnt_q))       fmt_word[k*MB +: MB] = acc_q[k*MB +: MB];
      else if (k == int'(cnt_q)) fmt_word[k*MB +: MB] = beat_mask;
      else                       fmt_word[k*MB +: MB] = {NUM_GROUPS{SPARSE_MASK_DFLT}};
    end
  end

  always_comb begin
    vld_pipe_d[1] = in_ready ? sp.in_valid : vld_pipe_q[1];
    vld_pipe_d[2] = s2_adv ? (vld_pipe_q[1] & fmt_ok) : vld_pipe_q[2];
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    fmt_valid_d   = fmt_valid_q & ~sp.fmt_ready;
    if (xfer) begin
      if (completes) begin
        cnt_d       = '0;
        acc_d       = '0;
        fmt_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
        acc_d = fmt_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q  <= '0;
      fmt_valid_q <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      fmt_valid_q <= fmt_valid_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (sp.in_valid && in_ready) begin
      s1_data_q <= sp.in_data;
      s1_last_q <= sp.in_last;
    end
    if (xfer) begin
      out_data_q <= kept;
      out_mask_q <= beat_mask;
    end
    if (xfer && completes) fmt_data_q <= fmt_word;
  end

  assign sp.in_ready  = in_ready;
  assign sp.out_valid = vld_pipe_q[2];
  assign sp.out_data  = out_data_q;
  assign sp.out_mask  = out_mask_q;
  assign sp.fmt_valid = fmt_valid_q;
  assign sp.fmt_data  = fmt_data_q;
endmodule

// File: tb/tb_tcu_sparse_packer.sv
// Directed and randomized-handshake checks of the 2:4 sparse packer.
module tb_tcu_sparse_packer;
  localparam int NG = 4, EW = 16, FW = 32;
  localparam int DW = NG*4*EW, OW = NG*2*EW, MW = NG*4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tcu_sparse_packer_if #(.NUM_GROUPS(NG), .ELEM_W(EW), .FMT_W(FW)) sp ();
  tcu_sparse_packer #(.NUM_GROUPS(NG), .ELEM_W(EW), .FMT_W(FW)) dut (
    .clk(clk), .reset(reset), .sp(sp)
  );

  int n_vec = 0, n_err = 0;
  logic [OW-1:0] got_d[$], exp_d[$];
  logic [MW-1:0] got_m[$], exp_m[$];
  logic [FW-1:0] got_f[$], exp_f[$];

  // Handshakes seen at negedge are exactly those completing at the next posedge.
  always @(negedge clk) if (!reset) begin
    if (sp.out_valid && sp.out_ready) begin
      got_d.push_back(sp.out_data);
      got_m.push_back(sp.out_mask);
    end
    if (sp.fmt_valid && sp.fmt_ready) got_f.push_back(sp.fmt_data);
  end

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    got_d.delete(); got_m.delete(); got_f.delete();
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    int t = 0;
    logic acc = 1'b0;
    sp.in_valid = 1'b1; sp.in_data = d; sp.in_last = last;
    while (!acc && t < 300) begin
      @(negedge clk); acc = sp.in_ready;
      @(posedge clk); #1; t++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    sp.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (got_d.size() < n && t < 300) begin @(posedge clk); #1; t++; end
    chk("out_count", got_d.size(), n);
  endtask

  task automatic wait_fmt(input int n);
    int t = 0;
    while (got_f.size() < n && t < 300) begin @(posedge clk); #1; t++; end
    chk("fmt_count", got_f.size(), n);
  endtask

  function automatic logic [DW-1:0] pat(input logic [3:0] m);
    logic [DW-1:0] d = '0;
    for (int g = 0; g < NG; g++)
      for (int e = 0; e < 4; e++)
        if (m[e]) d[(4*g+e)*EW +: EW] = 16'h3C00;
    return d;
  endfunction

  function automatic logic [15:0] rnd_elem();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    case ($urandom_range(0, 7))
      0: return 16'h0000; 1: return 16'h3C00; 2: return 16'hBC00; 3: return 16'h4000;
      4: return 16'hC000; 5: return 16'h7C00; 6: return 16'hFC00; default: return 16'h3800;
    endcase
  endfunction

  // Reference: pick max magnitude, then max of the rest, lowest index on ties.
  function automatic void model(input logic [DW-1:0] d, output logic [OW-1:0] od,
                                output logic [MW-1:0] om);
    logic [15:0] el[4];
    int b, s, lo, hi;
    od = '0; om = '0;
    for (int g = 0; g < NG; g++) begin
      for (int e = 0; e < 4; e++) el[e] = d[(4*g+e)*EW +: EW];
      b = 0;
      for (int e = 1; e < 4; e++) if (el[e][14:0] > el[b][14:0]) b = e;
      s = (b == 0) ? 1 : 0;
      for (int e = 0; e < 4; e++) if (e != b && el[e][14:0] > el[s][14:0]) s = e;
      lo = (b < s) ? b : s;
      hi = (b < s) ? s : b;
      om[4*g+lo] = 1'b1;
      om[4*g+hi] = 1'b1;
      od[2*g*EW +: EW]     = el[lo];
      od[(2*g+1)*EW +: EW] = el[hi];
    end
  endfunction

  logic [DW-1:0] rd;
  logic [OW-1:0] ed;
  logic [MW-1:0] em, mlo;
  logic          rlast, done;
  int            mcnt;

  initial begin
    sp.in_valid = 1'b0; sp.in_data = '0; sp.in_last = 1'b0;
    sp.out_ready = 1'b0; sp.fmt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", sp.out_valid, 0);
    chk("rst_fmt_valid", sp.fmt_valid, 0);
    chk("rst_in_ready", sp.in_ready, 0);
    reset = 1'b0; sp.out_ready = 1'b1; sp.fmt_ready = 1'b1;
    #1;
    chk("post_rst_in_ready", sp.in_ready, 1);

    // Basic selection, latency, ties and zero groups.
    clr();
    send({4{64'h3800_C000_0000_3C00}}, 1'b0);
    chk("lat_not_yet", sp.out_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid", sp.out_valid, 1);
    chk("g1_mask", sp.out_mask, 16'h5555);
    chk("g1_data", sp.out_data, {4{32'hC000_3C00}});
    send({64'h3800_C000_0000_3C00, 64'hBC00_3C00_0000_0000,
          64'h4000_4000_4000_4000, 64'h0}, 1'b1);
    wait_out(2);
    wait_fmt(1);
    chk("mix_mask", got_m[1], 16'h5C33);
    chk("mix_data", got_d[1], {32'hC000_3C00, 32'hBC00_3C00, 32'h4000_4000, 32'h0});
    chk("mix_fmt", got_f[0], 32'h5C33_5555);

    // Two-beat word; no format word until the second beat.
    clr();
    send(pat(4'b0011), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("two_no_fmt_early", sp.fmt_valid, 0);
    send(pat(4'b1100), 1'b0);
    wait_fmt(1);
    chk("two_fmt", got_f[0], 32'hCCCC_3333);
    chk("two_mask0", got_m[0], 16'h3333);
    chk("two_mask1", got_m[1], 16'hCCCC);

    // in_last on slot 0 pads, next beat restarts at slot 0.
    clr();
    send(pat(4'b1010), 1'b1);
    wait_fmt(1);
    chk("last_fmt", got_f[0], 32'h3333_AAAA);
    send(pat(4'b0011), 1'b0);
    send(pat(4'b1100), 1'b0);
    wait_fmt(2);
    chk("after_last_fmt", got_f[1], 32'hCCCC_3333);

    // Format backpressure across three words.
    clr();
    sp.fmt_ready = 1'b0;
    fork
      begin
        send(pat(4'b0011), 1'b0); send(pat(4'b0101), 1'b0);
        send(pat(4'b0110), 1'b0); send(pat(4'b1001), 1'b0);
        send(pat(4'b1010), 1'b0); send(pat(4'b1100), 1'b0);
      end
      begin
        repeat (15) @(posedge clk);
        #1;
        chk("bp_in_ready", sp.in_ready, 0);
        chk("bp_fmt_valid", sp.fmt_valid, 1);
        chk("bp_fmt_held", sp.fmt_data, 32'h5555_3333);
        chk("bp_no_pop", got_f.size(), 0);
        chk("bp_out_drained", got_d.size(), 3);
        sp.fmt_ready = 1'b1;
      end
    join
    wait_fmt(3);
    repeat (5) @(posedge clk);
    #1;
    chk("bp_fmt_total", got_f.size(), 3);
    chk("bp_w0", got_f[0], 32'h5555_3333);
    chk("bp_w1", got_f[1], 32'h9999_6666);
    chk("bp_w2", got_f[2], 32'hCCCC_AAAA);

    // Random data, random readies, against the reference model.
    clr(); exp_d.delete(); exp_m.delete(); exp_f.delete();
    done = 1'b0; mcnt = 0; mlo = '0;
    fork
      begin
        for (int n = 0; n < 1000; n++) begin
          for (int k = 0; k < NG*4; k++) rd[k*EW +: EW] = rnd_elem();
          rlast = (n == 999) || ($urandom_range(0, 4) == 0);
          model(rd, ed, em);
          exp_d.push_back(ed); exp_m.push_back(em);
          if (mcnt == 1 || rlast) begin
            exp_f.push_back((mcnt == 0) ? {16'h3333, em} : {em, mlo});
            mcnt = 0;
          end else begin
            mlo = em; mcnt = 1;
          end
          if ($urandom_range(0, 7) == 0) begin @(posedge clk); #1; end
          send(rd, rlast);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          sp.out_ready = ($urandom_range(0, 3) != 0);
          sp.fmt_ready = ($urandom_range(0, 2) != 0);
        end
        sp.out_ready = 1'b1; sp.fmt_ready = 1'b1;
      end
    join
    wait_out(exp_d.size());
    wait_fmt(exp_f.size());
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk("rnd_data", got_d[i], exp_d[i]);
      chk("rnd_mask", got_m[i], exp_m[i]);
    end
    for (int i = 0; i < exp_f.size() && i < got_f.size(); i++)
      chk("rnd_fmt", got_f[i], exp_f[i]);

    // Reset mid-stream drops in-flight beats and the partial word.
    clr();
    sp.out_ready = 1'b0;
    send(pat(4'b0110), 1'b0);
    send(pat(4'b1001), 1'b0);
    chk("pre_rst_out_valid", sp.out_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", sp.out_valid, 0);
    chk("mid_rst_fmt_valid", sp.fmt_valid, 0);
    reset = 1'b0; sp.out_ready = 1'b1;
    send(pat(4'b1100), 1'b1);
    wait_out(1);
    wait_fmt(1);
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_out_total", got_d.size(), 1);
    chk("post_rst_mask", got_m[0], 16'hCCCC);
    chk("post_rst_fmt", got_f[0], 32'h3333_CCCC);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
